joy_scanner: RTL and testbench
==============================

JOY_SCANNER -- requirements
Module: joy_scanner

Interface
REQ-001 Parameter CLK_DIV, default 16: clk12 cycles per JOY_CLK half-period; legal range 2..255.
REQ-002 Parameter DEBOUNCE, default 1: 1 = output bit updates only after two consecutive identical frames; 0 = every frame commits directly.
REQ-003 clk12  input  1  system clock; all logic is on its rising edge.
REQ-004 pll_lckd  input  1  asynchronous active-low reset.
REQ-005 scan_en  input  1  1 = scan continuously; 0 = stop at the next frame boundary or abort (REQ-014).
REQ-006 JOY_DATA  input  1  serial data from the external shift register; active-low buttons.
REQ-007 JOY_CLK  output  1  shift clock to the external register, registered.
REQ-008 JOY_LOAD  output  1  parallel-load strobe, active low, registered.
REQ-009 joystick1  output  12  player-1 bits; 1 = released.
REQ-010 joystick2  output  12  player-2 bits; 1 = released.
REQ-011 frame_done  output  1  one-clk12 pulse in the cycle the joystick outputs commit.

Function
REQ-012 Divider: div_cnt counts 0..CLK_DIV-1 and wraps; tick is asserted when div_cnt==CLK_DIV-1; JOY_CLK toggles on each tick; a rising tick is a tick with JOY_CLK==0.
REQ-013 FSM states:
- IDLE: JOY_CLK=0, JOY_LOAD=1, div_cnt held at 0.
- LOAD: period count pcnt=0, JOY_LOAD=0.
- GAP: pcnt=1, JOY_LOAD=1, no sample.
- SHIFT: pcnt=2..25.
- COMMIT: lasts one clk12 cycle.
REQ-014 Transitions:
- IDLE->LOAD on the clk12 cycle after scan_en=1.
- pcnt increments on each rising tick.
- LOAD->GAP at pcnt 0->1; GAP->SHIFT at 1->2.
- SHIFT->COMMIT on the rising tick that samples pcnt=25.
- COMMIT->LOAD if scan_en=1, else ->IDLE.
- scan_en=0 in LOAD, GAP or SHIFT aborts to IDLE at the next tick; the partial frame is discarded and outputs hold.
REQ-015 Sampling: JOY_DATA is captured into shadow bit k=pcnt-2 on the rising tick, i.e. the same clk12 edge that drives JOY_CLK high.
REQ-016 Bit map, k->output:
- 0..7 -> j1[8],j1[6],j1[5],j1[4],j1[3],j1[2],j1[1],j1[0]
- 8..15 -> j2[8],j2[6],j2[5],j2[4],j2[3],j2[2],j2[1],j2[0]
- 16..19 -> j2[10],j2[11],j2[9],j2[7]
- 20..23 -> j1[10],j1[11],j1[9],j1[7]
REQ-017 Frame length is 26 JOY_CLK periods = 52*CLK_DIV clk12 cycles, plus 1 COMMIT cycle; back-to-back frames have no other gap.
REQ-018 Commit, DEBOUNCE=0: joystick1/2 <= shadow, atomically in COMMIT.
REQ-019 Commit, DEBOUNCE=1: each output bit <= shadow bit only if it equals that bit of the previous completed frame (prev register); prev <= shadow every COMMIT.
REQ-020 frame_done=1 exactly in COMMIT, including when no output bit changes; it is 0 on aborted frames.
REQ-021 joystick1/2 never change outside COMMIT.

Reset
REQ-022 When pll_lckd=0: state=IDLE, div_cnt=0, pcnt=0, JOY_CLK=0, JOY_LOAD=1, frame_done=0, joystick1=joystick2=12'hFFF, shadow=prev=all ones; this takes effect immediately and asynchronously.
REQ-023 After pll_lckd rises, the first frame starts per REQ-014; a reset during a frame discards that frame.

Verification
REQ-024 CLK_DIV=4, scan_en=1, shift-register model all ones except k=0 and k=21 low, DEBOUNCE=0 -> after first frame_done, joystick1=12'h6FF, joystick2=12'hFFF; frame_done period = 209 clk12.
REQ-025 DEBOUNCE=1, button k=7 low for one frame only -> joystick1[0] stays 1; held low two frames -> joystick1[0]=0 at second frame_done.
REQ-026 scan_en dropped at pcnt=10 -> return to IDLE within CLK_DIV cycles; JOY_CLK=0, JOY_LOAD=1; no frame_done; outputs unchanged.
REQ-027 pll_lckd pulsed low mid-SHIFT with outputs non-FFF -> outputs 12'hFFF the same cycle; JOY_LOAD=1; scanning resumes from LOAD.
REQ-028 Protocol check, any CLK_DIV: JOY_LOAD low for exactly one JOY_CLK period per frame; exactly 24 samples per frame; each sample coincides with a JOY_CLK rising edge.

Source files
------------

// File: rtl/joy_scanner.sv
// Joystick scanner: strobes an external parallel-in shift register, clocks out 24 bits per frame
// and commits them (optionally debounced across two frames) to two 12-bit joystick words.
module joy_scanner #(
  parameter int unsigned CLK_DIV  = 16,
  parameter bit          DEBOUNCE = 1'b1
) (
  input  logic        clk12,
  input  logic        pll_lckd,
  input  logic        scan_en,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GAP    = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] PCNT_LAST = 5'd25;

  state_t      state_r, state_next_s;
  logic [7:0]  div_r, div_next_s;
  logic [4:0]  pcnt_r, pcnt_next_s, bit_idx_s;
  logic        joy_clk_r, joy_clk_next_s, joy_load_r, frame_done_r;
  logic        tick_s, rise_s, commit_s;
  logic [23:0] shadow_r, shadow_next_s, prev_r;
  logic [23:0] map_new_s, map_prev_s, map_eq_s, joy_next_s;
  logic [11:0] joy1_r, joy2_r;

  // Scan order k -> {joystick2, joystick1} bit position.
  function automatic logic [23:0] map_bits(input logic [23:0] s);
    logic [11:0] j1;
    logic [11:0] j2;
    j1 = {s[21], s[20], s[22], s[0], s[23], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
    j2 = {s[17], s[16], s[18], s[8], s[19], s[9], s[10], s[11], s[12], s[13], s[14], s[15]};
    return {j2, j1};
  endfunction

  // Next-state, divider, shift-clock and shadow capture.
  always_comb begin
    state_next_s   = state_r;
    div_next_s     = 8'd0;
    pcnt_next_s    = pcnt_r;
    joy_clk_next_s = joy_clk_r;
    shadow_next_s  = shadow_r;
    commit_s       = 1'b0;
    tick_s         = (div_r == DIV_LAST);
    rise_s         = tick_s & ~joy_clk_r;
    bit_idx_s      = pcnt_r - 5'd2;
    case (state_r)
      ST_IDLE: begin
        pcnt_next_s = 5'd0;
        // Enter LOAD with the clock high so the load strobe spans one full period.
        if (scan_en) begin
          state_next_s   = ST_LOAD;
          joy_clk_next_s = 1'b1;
        end else begin
          joy_clk_next_s = 1'b0;
        end
      end
      ST_LOAD, ST_GAP, ST_SHIFT: begin
        if (!tick_s) begin
          div_next_s = div_r + 8'd1;
        end else if (!scan_en) begin
          state_next_s   = ST_IDLE;
          pcnt_next_s    = 5'd0;
          joy_clk_next_s = 1'b0;
        end else if (rise_s) begin
          joy_clk_next_s = 1'b1;
          pcnt_next_s    = pcnt_r + 5'd1;
          case (state_r)
            ST_LOAD: state_next_s = ST_GAP;
            ST_GAP:  state_next_s = ST_SHIFT;
            ST_SHIFT: begin
              shadow_next_s[bit_idx_s] = JOY_DATA;
              if (pcnt_r == PCNT_LAST) begin
                state_next_s = ST_COMMIT;
                commit_s     = 1'b1;
              end else begin
                state_next_s = ST_SHIFT;
              end
            end
            default: state_next_s = ST_IDLE;
          endcase
        end else begin
          joy_clk_next_s = 1'b0;
        end
      end
      ST_COMMIT: begin
        pcnt_next_s = 5'd0;
        if (scan_en) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s   = ST_IDLE;
          joy_clk_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        pcnt_next_s    = 5'd0;
        joy_clk_next_s = 1'b0;
      end
    endcase
  end

  // Commit value: a bit moves only when it matches the previous completed frame.
  always_comb begin
    map_new_s  = map_bits(shadow_next_s);
    map_prev_s = map_bits(prev_r);
    map_eq_s   = ~(map_new_s ^ map_prev_s);
    if (DEBOUNCE) begin
      joy_next_s = (map_new_s & map_eq_s) | ({joy2_r, joy1_r} & ~map_eq_s);
    end else begin
      joy_next_s = map_new_s;
    end
  end

  // State register.
  always_ff @(posedge clk12 or negedge pll_lckd) begin
    if (!pll_lckd) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered outputs; joystick words load on the edge into COMMIT.
  always_ff @(posedge clk12 or negedge pll_lckd) begin
    if (!pll_lckd) begin
      div_r        <= 8'd0;
      pcnt_r       <= 5'd0;
      joy_clk_r    <= 1'b0;
      joy_load_r   <= 1'b1;
      frame_done_r <= 1'b0;
      shadow_r     <= 24'hFFFFFF;
      prev_r       <= 24'hFFFFFF;
      joy1_r       <= 12'hFFF;
      joy2_r       <= 12'hFFF;
    end else begin
      div_r        <= div_next_s;
      pcnt_r       <= pcnt_next_s;
      joy_clk_r    <= joy_clk_next_s;
      joy_load_r   <= (state_next_s != ST_LOAD);
      frame_done_r <= commit_s;
      shadow_r     <= shadow_next_s;
      if (commit_s) begin
        prev_r           <= shadow_next_s;
        {joy2_r, joy1_r} <= joy_next_s;
      end
    end
  end

  assign JOY_CLK    = joy_clk_r;
  assign JOY_LOAD   = joy_load_r;
  assign joystick1  = joy1_r;
  assign joystick2  = joy2_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_joy_scanner.sv
// Directed bench for joy_scanner: two instances (no debounce / debounce) fed by behavioural
// shift-register models, checked against hand-computed joystick words and frame timing.
module tb_joy_scanner;

  localparam logic [23:0] P_ONES = 24'hFFFFFF;
  localparam logic [23:0] P1     = 24'hDFFFFE;  // k0, k21 low
  localparam logic [23:0] P2     = 24'hFEFE7F;  // k7, k8, k16 low
  localparam logic [23:0] P3     = 24'h21FFFF;  // k17..20, k22, k23 low
  localparam logic [23:0] P4     = 24'hFF0181;  // k1..6, k9..15 low
  localparam logic [23:0] K7     = 24'hFFFF7F;  // k7 low

  logic        clk12 = 1'b0;
  logic        pll_lckd_s, scan_en0_s, scan_en1_s;
  logic        data0_s = 1'b1, data1_s = 1'b1;
  logic        jclk0_s, jload0_s, jclk1_s, jload1_s, fd0_s, fd1_s;
  logic [11:0] j1_0_s, j2_0_s, j1_1_s, j2_1_s;
  logic [23:0] pat0_r = 24'hFFFFFF, pat1_r = 24'hFFFFFF;
  logic [23:0] last0_r = 24'hFFFFFF, last1_r = 24'hFFFFFF;
  logic        pclk0_r = 1'b0, pclk1_r = 1'b0, pload0_r = 1'b1;
  int          cnt0 = 0, cnt1 = 0, low_len0 = 0, viol = 0, cyc = 0;
  int          n_checks = 0, n_fail = 0, t_prev = 0, n_fd = 0;

  joy_scanner #(.CLK_DIV(4), .DEBOUNCE(1'b0)) u_dut0 (
    .clk12(clk12), .pll_lckd(pll_lckd_s), .scan_en(scan_en0_s), .JOY_DATA(data0_s),
    .JOY_CLK(jclk0_s), .JOY_LOAD(jload0_s), .joystick1(j1_0_s), .joystick2(j2_0_s),
    .frame_done(fd0_s)
  );

  joy_scanner #(.CLK_DIV(4), .DEBOUNCE(1'b1)) u_dut1 (
    .clk12(clk12), .pll_lckd(pll_lckd_s), .scan_en(scan_en1_s), .JOY_DATA(data1_s),
    .JOY_CLK(jclk1_s), .JOY_LOAD(jload1_s), .joystick1(j1_1_s), .joystick2(j2_1_s),
    .frame_done(fd1_s)
  );

  // Clock generator.
  initial forever #5 clk12 = ~clk12;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk12);
    #2;
  endtask

  task automatic wait_fd0(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (fd0_s !== 1'b1 && n < budget);
    if (fd0_s !== 1'b1) check_eq("fd0_timeout", 32'(fd0_s), 32'd1);
  endtask

  task automatic wait_cnt0(input int target, input int budget);
    int n;
    n = 0;
    while (cnt0 != target && n < budget) begin
      step();
      n++;
    end
    if (cnt0 != target) check_eq("cnt0_timeout", 32'(cnt0), 32'(target));
  endtask

  // Shift-register models (bit k presented after the k+2-th clock rise since load), load-strobe
  // length and a monitor for joystick changes outside frame_done.
  initial forever begin
    @(posedge clk12);
    #1;
    cyc++;
    if (!jload0_s) cnt0 = 0;
    else if (jclk0_s && !pclk0_r) cnt0++;
    pclk0_r = jclk0_s;
    data0_s = (cnt0 >= 2 && cnt0 <= 25) ? pat0_r[cnt0 - 2] : 1'b1;
    if (!jload1_s) cnt1 = 0;
    else if (jclk1_s && !pclk1_r) cnt1++;
    pclk1_r = jclk1_s;
    data1_s = (cnt1 >= 2 && cnt1 <= 25) ? pat1_r[cnt1 - 2] : 1'b1;
    if (!jload0_s) low_len0 = pload0_r ? 1 : low_len0 + 1;
    pload0_r = jload0_s;
    if (pll_lckd_s) begin
      if ({j1_0_s, j2_0_s} != last0_r && !fd0_s) viol++;
      if ({j1_1_s, j2_1_s} != last1_r && !fd1_s) viol++;
    end
    last0_r = {j1_0_s, j2_0_s};
    last1_r = {j1_1_s, j2_1_s};
  end

  // Directed sequence.
  initial begin
    pll_lckd_s = 1'b0;
    scan_en0_s = 1'b0;
    scan_en1_s = 1'b0;
    repeat (3) step();
    check_eq("rst_j1", j1_0_s, 12'hFFF);
    check_eq("rst_j2", j2_0_s, 12'hFFF);
    check_eq("rst_clk", jclk0_s, 1'b0);
    check_eq("rst_load", jload0_s, 1'b1);
    check_eq("rst_fd", fd0_s, 1'b0);

    @(negedge clk12);
    pll_lckd_s = 1'b1;
    scan_en0_s = 1'b1;
    scan_en1_s = 1'b1;
    pat0_r = P1;
    wait_fd0(400);
    t_prev = cyc;
    check_eq("f1_j1", j1_0_s, 12'h6FF);
    check_eq("f1_j2", j2_0_s, 12'hFFF);
    check_eq("f1_load_len", 32'(low_len0), 32'd8);
    check_eq("f1_clk_rises", 32'(cnt0), 32'd26);
    check_eq("f1_fd1", fd1_s, 1'b1);
    check_eq("f1_deb_j1", j1_1_s, 12'hFFF);
    check_eq("f1_deb_j2", j2_1_s, 12'hFFF);
    pat0_r = P2;
    pat1_r = K7;
    step();
    check_eq("fd_pulse", fd0_s, 1'b0);

    wait_fd0(400);
    check_eq("period_f2", 32'(cyc - t_prev), 32'd209);
    t_prev = cyc;
    check_eq("f2_j1", j1_0_s, 12'hFFE);
    check_eq("f2_j2", j2_0_s, 12'hAFF);
    check_eq("f2_fd1", fd1_s, 1'b1);
    check_eq("f2_deb_j1", j1_1_s, 12'hFFF);
    pat0_r = P3;
    pat1_r = P_ONES;

    wait_fd0(400);
    check_eq("period_f3", 32'(cyc - t_prev), 32'd209);
    check_eq("f3_j1", j1_0_s, 12'h97F);
    check_eq("f3_j2", j2_0_s, 12'h57F);
    check_eq("f3_deb_j1", j1_1_s, 12'hFFF);
    pat0_r = P4;
    pat1_r = K7;

    wait_fd0(400);
    check_eq("f4_j1", j1_0_s, 12'hF81);
    check_eq("f4_j2", j2_0_s, 12'hF80);
    check_eq("f4_deb_j1", j1_1_s, 12'hFFF);

    wait_fd0(400);
    check_eq("f5_j1", j1_0_s, 12'hF81);
    check_eq("f5_fd1", fd1_s, 1'b1);
    check_eq("f5_deb_j1", j1_1_s, 12'hFFE);
    check_eq("f5_deb_j2", j2_1_s, 12'hFFF);
    pat0_r = P_ONES;

    // Abort at pcnt=10.
    wait_cnt0(10, 400);
    scan_en0_s = 1'b0;
    n_fd = 0;
    repeat (4) begin
      step();
      if (fd0_s) n_fd++;
    end
    check_eq("abort_clk", jclk0_s, 1'b0);
    check_eq("abort_load", jload0_s, 1'b1);
    repeat (300) begin
      step();
      if (fd0_s) n_fd++;
    end
    check_eq("abort_no_fd", 32'(n_fd), 32'd0);
    check_eq("abort_j1", j1_0_s, 12'hF81);
    check_eq("abort_j2", j2_0_s, 12'hF80);
    check_eq("abort_idle_clk", jclk0_s, 1'b0);

    pat0_r = P2;
    scan_en0_s = 1'b1;
    wait_fd0(400);
    check_eq("resume_j1", j1_0_s, 12'hFFE);
    check_eq("resume_j2", j2_0_s, 12'hAFF);

    // Reset pulse mid-SHIFT.
    wait_cnt0(12, 400);
    pll_lckd_s = 1'b0;
    #1;
    check_eq("mrst_j1", j1_0_s, 12'hFFF);
    check_eq("mrst_j2", j2_0_s, 12'hFFF);
    check_eq("mrst_load", jload0_s, 1'b1);
    check_eq("mrst_clk", jclk0_s, 1'b0);
    check_eq("mrst_deb_j1", j1_1_s, 12'hFFF);
    @(posedge clk12);
    @(negedge clk12);
    pll_lckd_s = 1'b1;
    step();
    check_eq("post_rst_load", jload0_s, 1'b0);
    wait_fd0(400);
    check_eq("post_rst_j1", j1_0_s, 12'hFFE);
    check_eq("post_rst_j2", j2_0_s, 12'hAFF);
    check_eq("post_rst_load_len", 32'(low_len0), 32'd8);
    check_eq("post_rst_fd1", fd1_s, 1'b1);
    check_eq("post_rst_deb_j1", j1_1_s, 12'hFFF);

    step();
    check_eq("change_outside_commit", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
